// File: rtl/ctrl_pipe_n.sv
// Parametrised control-word pipeline: carries decoded control through STAGES registers,
// evaluates the ARM condition code at execute against an internal NZCV register.
module ctrl_pipe_n #(
  parameter int              STAGES    = 3,
  parameter int              CW        = 16,
  parameter logic [CW-1:0]   GATE_MASK = CW'(16'h000F),
  parameter int              PCSRC_BIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        ctrl_d,
  input  logic [3:0]           cond_d,
  input  logic [1:0]           flagwr_d,
  input  logic [3:0]           alu_flags,
  input  logic [STAGES-1:0]    stall,
  input  logic [STAGES-1:0]    flush,
  output logic [STAGES*CW-1:0] ctrl_q,
  output logic                 cond_ex,
  output logic [3:0]           flags,
  output logic                 carry_in,
  output logic                 pc_wr_pending
);

  logic [CW-1:0] stageCtrl_q [STAGES];
  logic [CW-1:0] stageCtrl_d [STAGES];
  logic [CW-1:0] slice       [STAGES];
  logic [3:0]    s0Cond_q, s0Cond_d;
  logic [1:0]    s0Flagwr_q, s0Flagwr_d;
  logic [3:0]    flags_q, flags_d;
  logic          flagN, flagZ, flagC, flagV;
  logic          flagWriteOk;
  logic          pcPending;

  assign flagN = flags_q[3];
  assign flagZ = flags_q[2];
  assign flagC = flags_q[1];
  assign flagV = flags_q[0];

  always_comb begin
    cond_ex = 1'b0;
    case (s0Cond_q)
      4'd0:    cond_ex = flagZ;
      4'd1:    cond_ex = ~flagZ;
      4'd2:    cond_ex = flagC;
      4'd3:    cond_ex = ~flagC;
      4'd4:    cond_ex = flagN;
      4'd5:    cond_ex = ~flagN;
      4'd6:    cond_ex = flagV;
      4'd7:    cond_ex = ~flagV;
      4'd8:    cond_ex = flagC & ~flagZ;
      4'd9:    cond_ex = ~flagC | flagZ;
      4'd10:   cond_ex = (flagN == flagV);
      4'd11:   cond_ex = (flagN != flagV);
      4'd12:   cond_ex = ~flagZ & (flagN == flagV);
      4'd13:   cond_ex = flagZ | (flagN != flagV);
      4'd14:   cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Slice 0 is the only gated view; everything downstream stores already-gated words.
  always_comb begin
    ctrl_q   = '0;
    slice[0] = (stageCtrl_q[0] & ~GATE_MASK) | (stageCtrl_q[0] & GATE_MASK & {CW{cond_ex}});
    for (int k = 1; k < STAGES; k++) begin
      slice[k] = stageCtrl_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      ctrl_q[k*CW +: CW] = slice[k];
    end
  end

  always_comb begin
    s0Cond_d       = s0Cond_q;
    s0Flagwr_d     = s0Flagwr_q;
    stageCtrl_d[0] = stageCtrl_q[0];
    if (flush[0]) begin
      stageCtrl_d[0] = '0;
      s0Cond_d       = '0;
      s0Flagwr_d     = '0;
    end else if (!stall[0]) begin
      stageCtrl_d[0] = ctrl_d;
      s0Cond_d       = cond_d;
      s0Flagwr_d     = flagwr_d;
    end
    for (int k = 1; k < STAGES; k++) begin
      stageCtrl_d[k] = stageCtrl_q[k];
      if (flush[k]) begin
        stageCtrl_d[k] = '0;
      end else if (stall[k]) begin
        stageCtrl_d[k] = stageCtrl_q[k];
      end else if (stall[k-1]) begin
        stageCtrl_d[k] = '0;
      end else begin
        stageCtrl_d[k] = slice[k-1];
      end
    end
  end

  // Flags commit only on the cycle the execute instruction actually leaves stage 0.
  assign flagWriteOk = cond_ex & ~stall[0] & ~flush[0];

  always_comb begin
    flags_d = flags_q;
    if (flagWriteOk && s0Flagwr_q[1]) flags_d[3:2] = alu_flags[3:2];
    if (flagWriteOk && s0Flagwr_q[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stageCtrl_q[k] <= '0;
      end
      s0Cond_q   <= '0;
      s0Flagwr_q <= '0;
      flags_q    <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stageCtrl_q[k] <= stageCtrl_d[k];
      end
      s0Cond_q   <= s0Cond_d;
      s0Flagwr_q <= s0Flagwr_d;
      flags_q    <= flags_d;
    end
  end

  // The last stage performs the PC write, so it no longer counts as pending.
  always_comb begin
    pcPending = ctrl_d[PCSRC_BIT];
    for (int k = 0; k < STAGES - 1; k++) begin
      pcPending = pcPending | slice[k][PCSRC_BIT];
    end
  end

  assign pc_wr_pending = pcPending;
  assign flags         = flags_q;
  assign carry_in      = flags_q[1];

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// Self-checking bench for ctrl_pipe_n: directed scenarios plus randomized traffic
// compared against a behavioural pipeline model.
module tb_ctrl_pipe_n;

  localparam int          S    = 3;
  localparam int          W    = 16;
  localparam logic [15:0] MASK = 16'h000F;
  localparam int          PCB  = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ctrlD;
  logic [3:0]   condD;
  logic [1:0]   flagwrD;
  logic [3:0]   aluFlags;
  logic [S-1:0] stallV;
  logic [S-1:0] flushV;

  logic [S*W-1:0] ctrlQ;
  logic           condEx;
  logic [3:0]     flagsO;
  logic           carryIn;
  logic           pcPend;

  int testCount = 0;
  int failCount = 0;

  logic [W-1:0] mCtrl [S];
  logic [3:0]   mCond;
  logic [1:0]   mFlagwr;
  logic [3:0]   mFlags;
  logic         lastPending;

  ctrl_pipe_n #(.STAGES(S), .CW(W), .GATE_MASK(MASK), .PCSRC_BIT(PCB)) dut (
    .clk          (clk),
    .reset        (rst),
    .ctrl_d       (ctrlD),
    .cond_d       (condD),
    .flagwr_d     (flagwrD),
    .alu_flags    (aluFlags),
    .stall        (stallV),
    .flush        (flushV),
    .ctrl_q       (ctrlQ),
    .cond_ex      (condEx),
    .flags        (flagsO),
    .carry_in     (carryIn),
    .pc_wr_pending(pcPend)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Odd condition codes are the inverse of the even code below them.
  function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [W-1:0] modelSlice(input int k);
    if (k != 0) return mCtrl[k];
    return condPass(mCond, mFlags) ? mCtrl[0] : (mCtrl[0] & ~MASK);
  endfunction

  function automatic logic [S*W-1:0] modelFlat();
    logic [S*W-1:0] r;
    r = '0;
    for (int k = 0; k < S; k++) r[k*W +: W] = modelSlice(k);
    return r;
  endfunction

  function automatic logic modelPending();
    logic         p;
    logic [W-1:0] w;
    p = ctrlD[PCB];
    for (int k = 0; k < S - 1; k++) begin
      w = modelSlice(k);
      p = p | w[PCB];
    end
    return p;
  endfunction

  task automatic modelStep();
    logic [W-1:0] nC [S];
    logic         pass;
    if (rst) begin
      for (int k = 0; k < S; k++) mCtrl[k] = '0;
      mCond = '0; mFlagwr = '0; mFlags = '0;
      return;
    end
    pass = condPass(mCond, mFlags);
    for (int k = 0; k < S; k++) begin
      if (flushV[k])                nC[k] = '0;
      else if (stallV[k])           nC[k] = mCtrl[k];
      else if (k > 0 && stallV[k-1]) nC[k] = '0;
      else                          nC[k] = (k == 0) ? ctrlD : modelSlice(k - 1);
    end
    if (!stallV[0] && !flushV[0] && pass) begin
      if (mFlagwr[1]) mFlags[3:2] = aluFlags[3:2];
      if (mFlagwr[0]) mFlags[1:0] = aluFlags[1:0];
    end
    if (flushV[0]) begin
      mCond = '0; mFlagwr = '0;
    end else if (!stallV[0]) begin
      mCond = condD; mFlagwr = flagwrD;
    end
    for (int k = 0; k < S; k++) mCtrl[k] = nC[k];
  endtask

  task automatic applyStimulus(input logic r, input logic [W-1:0] c, input logic [3:0] cd,
                               input logic [1:0] fw, input logic [3:0] alu,
                               input logic [S-1:0] st, input logic [S-1:0] fl);
    @(negedge clk);
    rst = r; ctrlD = c; condD = cd; flagwrD = fw; aluFlags = alu; stallV = st; flushV = fl;
    #1;
    lastPending = pcPend;
    checkOutput("pend_pre", pcPend, modelPending());
    checkOutput("condex_pre", condEx, condPass(mCond, mFlags));
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("ctrl_q", ctrlQ, modelFlat());
    checkOutput("flags", flagsO, mFlags);
    checkOutput("carry_in", carryIn, mFlags[1]);
    checkOutput("cond_ex", condEx, condPass(mCond, mFlags));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 4'd0, 2'b00, 4'd0, '0, '0);
  endtask

  function automatic logic [W-1:0] sliceOf(input int k);
    return ctrlQ[k*W +: W];
  endfunction

  initial begin
    rst = 1'b1; ctrlD = '0; condD = '0; flagwrD = '0; aluFlags = '0; stallV = '0; flushV = '0;
    for (int k = 0; k < S; k++) mCtrl[k] = '0;
    mCond = '0; mFlagwr = '0; mFlags = '0; lastPending = 1'b0;
    @(posedge clk);
    @(posedge clk);

    applyStimulus(1'b1, 16'h0001, 4'd0, 2'b00, 4'd0, '0, '0);
    checkOutput("rst_ctrl_q", ctrlQ, 48'h0);
    checkOutput("rst_flags", flagsO, 4'h0);
    checkOutput("rst_carry", carryIn, 1'b0);
    checkOutput("rst_cond_ex", condEx, 1'b0);
    checkOutput("rst_pend_ctrl_d", pcPend, 1'b1);
    idle(1);

    applyStimulus(1'b0, 16'h00F0, 4'd14, 2'b00, 4'd0, '0, '0);
    checkOutput("flow_s0", sliceOf(0), 16'h00F0);
    idle(1);
    checkOutput("flow_s1", sliceOf(1), 16'h00F0);
    checkOutput("flow_s0_empty", sliceOf(0), 16'h0000);
    idle(1);
    checkOutput("flow_s2", sliceOf(2), 16'h00F0);
    idle(1);
    checkOutput("flow_drained", ctrlQ, 48'h0);

    applyStimulus(1'b0, 16'h00FF, 4'd0, 2'b00, 4'd0, '0, '0);
    checkOutput("cfail_s0", sliceOf(0), 16'h00F0);
    checkOutput("cfail_cond_ex", condEx, 1'b0);
    idle(1);
    checkOutput("cfail_s1", sliceOf(1), 16'h00F0);
    idle(2);

    applyStimulus(1'b0, 16'h0000, 4'd14, 2'b11, 4'd0, '0, '0);
    applyStimulus(1'b0, 16'h000F, 4'd0, 2'b00, 4'b0100, '0, '0);
    checkOutput("fupd_flags", flagsO, 4'b0100);
    checkOutput("fupd_cond_ex", condEx, 1'b1);
    checkOutput("fupd_s0", sliceOf(0), 16'h000F);
    idle(3);

    applyStimulus(1'b0, 16'h0010, 4'd14, 2'b11, 4'd0, '0, '0);
    applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, 4'b1000, 3'b001, '0);
    checkOutput("stall1_s0", sliceOf(0), 16'h0010);
    checkOutput("stall1_s1", sliceOf(1), 16'h0000);
    checkOutput("stall1_flags", flagsO, 4'b0100);
    applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, 4'b0001, 3'b001, '0);
    checkOutput("stall2_s0", sliceOf(0), 16'h0010);
    checkOutput("stall2_s1", sliceOf(1), 16'h0000);
    checkOutput("stall2_flags", flagsO, 4'b0100);
    applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, 4'b0001, '0, '0);
    checkOutput("release_flags", flagsO, 4'b0001);
    checkOutput("release_s1", sliceOf(1), 16'h0010);
    applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, 4'b1000, '0, '0);
    checkOutput("after_flags", flagsO, 4'b0001);
    idle(2);

    applyStimulus(1'b0, 16'h00F0, 4'd14, 2'b00, 4'd0, '0, '0);
    idle(1);
    checkOutput("fl_pre_s1", sliceOf(1), 16'h00F0);
    applyStimulus(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 3'b010, 3'b010);
    checkOutput("fl_s1", sliceOf(1), 16'h0000);
    checkOutput("fl_s2_bubble", sliceOf(2), 16'h0000);
    idle(2);

    applyStimulus(1'b0, 16'h0001, 4'd14, 2'b00, 4'd0, '0, '0);
    checkOutput("pc_D", lastPending, 1'b1);
    idle(1);
    checkOutput("pc_E", lastPending, 1'b1);
    idle(1);
    checkOutput("pc_M", lastPending, 1'b1);
    idle(1);
    checkOutput("pc_W", lastPending, 1'b0);
    applyStimulus(1'b0, 16'h0001, 4'd0, 2'b00, 4'd0, '0, '0);
    checkOutput("pcf_D", lastPending, 1'b1);
    idle(1);
    checkOutput("pcf_E", lastPending, 1'b0);
    idle(1);
    checkOutput("pcf_M", lastPending, 1'b0);

    applyStimulus(1'b0, 16'h00F1, 4'd14, 2'b11, 4'd0, '0, '0);
    applyStimulus(1'b0, 16'h0031, 4'd14, 2'b00, 4'b1111, '0, '0);
    checkOutput("mid_flags", flagsO, 4'b1111);
    applyStimulus(1'b1, 16'h0000, 4'd0, 2'b00, 4'b1111, '0, '0);
    checkOutput("mrst_ctrl_q", ctrlQ, 48'h0);
    checkOutput("mrst_flags", flagsO, 4'h0);
    checkOutput("mrst_carry", carryIn, 1'b0);
    checkOutput("mrst_cond_ex", condEx, 1'b0);
    checkOutput("mrst_pend", pcPend, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [S-1:0] st, fl;
      for (int k = 0; k < S; k++) begin
        st[k] = ($urandom_range(0, 4) == 0);
        fl[k] = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(($urandom_range(0, 99) == 0), W'($urandom), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), st, fl);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
